// File: rtl/dm_store_buffer.sv
// Purpose : data-memory responder; stores go to a FIFO store buffer that drains in the background to a slow RAM.
// Latency : stores and buffer-hit loads complete in the request cycle; a load miss stalls for RAM_LAT+1 cycles.
// Backpr. : stall is raised for a store to a full buffer (until a drain pop frees an entry) and for a load miss.
module dm_store_buffer #(
    parameter int AW       = 7,
    parameter int SB_DEPTH = 4,
    parameter int RAM_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AW-1:0]               addr,
    input  logic                        rd,
    input  logic                        wr,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata,
    output logic                        stall,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2,
        S_RVAL  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;
    logic [31:0]     r_rd_lat;
    logic [AW-1:0]   r_sb_addr [SB_DEPTH];
    logic [31:0]     r_sb_data [SB_DEPTH];
    logic [31:0]     r_ram     [0:(1<<AW)-1];

    logic            w_load;
    logic            w_hit;
    logic [31:0]     w_hit_data;
    logic            w_miss;
    logic            w_full;
    logic            w_op_last;
    logic            w_pop;
    logic            w_push;
    logic            w_stall;
    logic [PW:0]     w_count_nxt;

    // A simultaneous rd+wr is handled as a plain store, so only rd without wr is a load.
    assign w_load    = rd & ~wr;
    assign w_full    = (r_count == (PW+1)'(SB_DEPTH));
    assign w_op_last = (r_cnt == '0);
    assign w_pop     = (r_state == S_DRAIN) && w_op_last;
    assign w_push    = wr && (!w_full || w_pop);
    assign w_miss    = w_load && !w_hit;

    // Search valid entries oldest to youngest so the youngest matching store wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (((PW+1)'(i) < r_count) && (r_sb_addr[r_head + PW'(i)] == addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_sb_data[r_head + PW'(i)];
            end
        end
    end

    // Occupancy after this edge: a push and a pop in the same cycle cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Stall on a store that finds no room, or a load miss until the RVAL cycle delivers the word.
    assign w_stall  = (wr && w_full && !w_pop) || (w_miss && (r_state != S_RVAL));
    assign stall    = w_stall;
    assign rdata    = (w_load && !w_stall) ? ((r_state == S_RVAL) ? r_rd_lat : w_hit_data) : 32'd0;
    assign sb_count = r_count;
    assign sb_empty = (r_count == '0) && (r_state == S_IDLE);

    // Buffer payload; only the pointers need reset since occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sb_addr[r_tail] <= addr;
            r_sb_data[r_tail] <= wdata;
        end
    end

    // Buffer pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // RAM write of the head entry in the last drain cycle; RAM contents survive reset, an abandoned drain writes nothing.
    always_ff @(posedge clk) begin
        if (!reset && w_pop) begin
            r_ram[r_sb_addr[r_head]] <= r_sb_data[r_head];
        end
    end

    // Control FSM: a pending load miss takes priority over starting another drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd_lat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state <= S_READ;
                        r_cnt   <= CW'(RAM_LAT-1);
                    end else if (r_count != '0) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CW'(RAM_LAT-1);
                    end
                end
                S_DRAIN: begin
                    if (w_op_last) begin
                        if (w_miss) begin
                            r_state <= S_READ;
                            r_cnt   <= CW'(RAM_LAT-1);
                        end else if (w_count_nxt != '0) begin
                            r_cnt   <= CW'(RAM_LAT-1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_READ: begin
                    if (w_op_last) begin
                        r_rd_lat <= r_ram[addr];
                        r_state  <= S_RVAL;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

    localparam int AW    = 7;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    localparam int OP_NONE  = 0;
    localparam int OP_DRAIN = 1;
    localparam int OP_READ  = 2;
    localparam int OP_RVAL  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic [2:0]    sb_count;
    logic          sb_empty;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dm_store_buffer #(.AW(AW), .SB_DEPTH(DEPTH), .RAM_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .sb_count (sb_count),
        .sb_empty (sb_empty)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0] mq_a [$];
    logic [31:0]   mq_d [$];
    logic [31:0]   mmem [128];
    int            op   = OP_NONE;
    int            left = 0;
    logic [31:0]   mlat = 32'd0;

    initial begin
        for (int i = 0; i < 128; i++) mmem[i] = 32'd0;
    end

    function automatic void model_lookup(output logic hit, output logic [31:0] hd);
        hit = 1'b0;
        hd  = 32'd0;
        for (int i = mq_a.size() - 1; i >= 0; i--) begin
            if (mq_a[i] == addr) begin
                hit = 1'b1;
                hd  = mq_d[i];
                break;
            end
        end
    endfunction

    function automatic void model_out(output logic exp_stall, output logic [31:0] exp_rd);
        logic hit, load, pop_now, full;
        logic [31:0] hd;
        model_lookup(hit, hd);
        load      = rd && !wr;
        pop_now   = (op == OP_DRAIN) && (left == 1);
        full      = (mq_a.size() == DEPTH);
        exp_stall = (wr && full && !pop_now) || (load && !hit && op != OP_RVAL);
        exp_rd    = (load && !exp_stall) ? ((op == OP_RVAL) ? mlat : hd) : 32'd0;
    endfunction

    always @(posedge clk) begin : model_upd
        logic hit, load, pop_now, full, miss, push;
        logic [31:0] hd;
        int size_before;
        if (reset) begin
            mq_a.delete();
            mq_d.delete();
            op   = OP_NONE;
            left = 0;
            mlat = 32'd0;
        end else begin
            model_lookup(hit, hd);
            load        = rd && !wr;
            pop_now     = (op == OP_DRAIN) && (left == 1);
            full        = (mq_a.size() == DEPTH);
            miss        = load && !hit;
            push        = wr && (!full || pop_now);
            size_before = mq_a.size();
            if (pop_now) begin
                mmem[mq_a[0]] = mq_d[0];
                void'(mq_a.pop_front());
                void'(mq_d.pop_front());
            end
            if (push) begin
                mq_a.push_back(addr);
                mq_d.push_back(wdata);
            end
            case (op)
                OP_NONE: begin
                    if (miss) begin op = OP_READ; left = LAT; end
                    else if (size_before > 0) begin op = OP_DRAIN; left = LAT; end
                end
                OP_DRAIN: begin
                    if (left == 1) begin
                        if (miss) begin op = OP_READ; left = LAT; end
                        else if (mq_a.size() > 0) left = LAT;
                        else op = OP_NONE;
                    end else left = left - 1;
                end
                OP_READ: begin
                    if (left == 1) begin mlat = mmem[addr]; op = OP_RVAL; end
                    else left = left - 1;
                end
                default: op = OP_NONE;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic        es;
        logic [31:0] er;
        if (chk_en) begin
            model_out(es, er);
            check32("cyc_stall", {31'd0, stall}, {31'd0, es});
            check32("cyc_rdata", rdata, er);
            check32("cyc_sb_count", {29'd0, sb_count}, 32'(mq_a.size()));
            check32("cyc_sb_empty", {31'd0, sb_empty}, {31'd0, (mq_a.size() == 0) && (op == OP_NONE)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic r, input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                          output int stalls, output logic [31:0] val, output int cnt);
        rd = r; wr = w; addr = a; wdata = d;
        stalls = 0; val = 32'd0; cnt = 0;
        while (1'b1) begin
            @(negedge clk);
            if (!stall) begin
                val = rdata;
                cnt = int'(sb_count);
                break;
            end
            stalls++;
            if (stalls > 40) begin
                checks++;
                errors++;
                $display("FAIL access_timeout: addr %0d still stalled after %0d cycles, required release", a, stalls);
                break;
            end
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        @(negedge clk);
        while (!sb_empty && n < 400) begin
            @(negedge clk);
            n++;
        end
        check32("wait_sb_empty", {31'd0, sb_empty}, 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          s;
        int          c;
        logic [31:0] v;
        int          st [8];
        int          ct [8];

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check32("reset_stall", {31'd0, stall}, 32'd0);
        check32("reset_rdata", rdata, 32'd0);
        check32("reset_sb_count", {29'd0, sb_count}, 32'd0);
        check32("reset_sb_empty", {31'd0, sb_empty}, 32'd1);
        @(posedge clk); #1;

        // RAM power-up contents are zero: establish that explicitly through the store path.
        for (int i = 0; i < 128; i++) access(1'b0, 1'b1, AW'(i), 32'd0, s, v, c);
        wait_empty();
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // 1: miss straight after reset.
        access(1'b1, 1'b0, 7'd5, 32'd0, s, v, c);
        check32("t1_stall_cycles", 32'(s), 32'd3);
        check32("t1_rdata", v, 32'd0);
        @(negedge clk);
        check32("t1_idle_after", {31'd0, sb_empty}, 32'd1);
        @(posedge clk); #1;

        // 2: store then forwarded load.
        access(1'b0, 1'b1, 7'd3, 32'hDEADBEEF, s, v, c);
        access(1'b1, 1'b0, 7'd3, 32'd0, s, v, c);
        check32("t2_stall_cycles", 32'(s), 32'd0);
        check32("t2_rdata", v, 32'hDEADBEEF);

        // 3: youngest match wins.
        access(1'b0, 1'b1, 7'd7, 32'h00000011, s, v, c);
        access(1'b0, 1'b1, 7'd7, 32'h00000022, s, v, c);
        access(1'b1, 1'b0, 7'd7, 32'd0, s, v, c);
        check32("t3_stall_cycles", 32'(s), 32'd0);
        check32("t3_rdata", v, 32'h00000022);
        wait_empty();

        // 4: back-to-back stores until the buffer is full.
        for (int i = 1; i <= 7; i++) begin
            access(1'b0, 1'b1, AW'(i), 32'h100 + 32'(i), s, v, c);
            st[i] = s;
            ct[i] = c;
        end
        check32("t4_store5_stalls", 32'(st[5]), 32'd0);
        check32("t4_store6_stalls", 32'(st[6]), 32'd0);
        check32("t4_store6_count", 32'(ct[6]), 32'd4);
        check32("t4_full_stalls", 32'(st[7]), 32'd1);
        check32("t4_full_accept_count", 32'(ct[7]), 32'd4);
        @(negedge clk);
        check32("t4_count_after_pop", {29'd0, sb_count}, 32'd4);
        @(posedge clk); #1;
        wait_empty();
        access(1'b1, 1'b0, 7'd4, 32'd0, s, v, c);
        check32("t4_rd4_stalls", 32'(s), 32'd3);
        check32("t4_rd4_rdata", v, 32'h00000104);
        access(1'b1, 1'b0, 7'd7, 32'd0, s, v, c);
        check32("t4_rd7_rdata", v, 32'h00000107);

        // 5: load of a drained store goes through the RAM.
        access(1'b0, 1'b1, 7'd9, 32'h00000055, s, v, c);
        wait_empty();
        access(1'b1, 1'b0, 7'd9, 32'd0, s, v, c);
        check32("t5_stall_cycles", 32'(s), 32'd3);
        check32("t5_rdata", v, 32'h00000055);

        // rd and wr together: treated as a store, rdata stays 0.
        access(1'b1, 1'b1, 7'd30, 32'h00000099, s, v, c);
        check32("rdwr_stall", 32'(s), 32'd0);
        check32("rdwr_rdata", v, 32'd0);
        wait_empty();
        access(1'b1, 1'b0, 7'd30, 32'd0, s, v, c);
        check32("rdwr_stored", v, 32'h00000099);

        // 6: reset mid-drain discards the buffered stores.
        access(1'b0, 1'b1, 7'd22, 32'h00000077, s, v, c);
        wait_empty();
        for (int i = 20; i <= 23; i++) access(1'b0, 1'b1, AW'(i), 32'hA0 + 32'(i), s, v, c);
        @(negedge clk);
        check32("t6_count_mid_drain", {29'd0, sb_count}, 32'd3);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check32("t6_count_reset", {29'd0, sb_count}, 32'd0);
        check32("t6_empty_reset", {31'd0, sb_empty}, 32'd1);
        check32("t6_stall_reset", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        access(1'b1, 1'b0, 7'd22, 32'd0, s, v, c);
        check32("t6_rd22_old", v, 32'h00000077);
        access(1'b1, 1'b0, 7'd21, 32'd0, s, v, c);
        check32("t6_rd21_old", v, 32'd0);
        access(1'b1, 1'b0, 7'd23, 32'd0, s, v, c);
        check32("t6_rd23_old", v, 32'd0);
        access(1'b1, 1'b0, 7'd20, 32'd0, s, v, c);
        check32("t6_rd20_drained", v, 32'h000000B4);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
